// File: rtl/rmii_pkg.sv
// Shared RMII definitions: speed codes, CRC-32 constants and the receiver state encoding.
package rmii_pkg;

    localparam logic [1:0]  SPEED_CODE_10_MEGABIT  = 2'd0;
    localparam logic [1:0]  SPEED_CODE_100_MEGABIT = 2'd1;

    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECEIVE,
        S_FINISH
    } rx_state_t;

endpackage

// File: rtl/rmii_crc32_byte.sv
// Combinational CRC-32 (reflected, LSB-first) update of a running register by one byte.
module rmii_crc32_byte
    import rmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data_in[i]) ? CRC32_POLY_REFLECTED : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rmii_frame_receiver.sv
// Delimits RMII byte frames by gap timeout or first-byte flag, checks CRC-32 and strips the FCS
// through a 5-deep delay line, reporting length and error status on the last payload beat.
module rmii_frame_receiver
    import rmii_pkg::*;
#(
    parameter int GAP_CYCLES_100  = 8,
    parameter int GAP_CYCLES_10   = 80,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [8:0]  packaged_data,
    input  logic        packaged_data_valid,
    input  logic [1:0]  speed_code,
    output logic [7:0]  frame_data,
    output logic        frame_data_valid,
    output logic        frame_data_last,
    output logic        frame_crc_error,
    output logic        frame_length_error,
    output logic [10:0] frame_length,
    output logic        runt_drop_pulse
);

    localparam logic [7:0]  GAP_LIMIT_100 = 8'(GAP_CYCLES_100 - 1);
    localparam logic [7:0]  GAP_LIMIT_10  = 8'(GAP_CYCLES_10 - 1);
    localparam logic [11:0] MIN_BYTES     = 12'(MIN_FRAME_BYTES);
    localparam logic [11:0] MAX_BYTES     = 12'(MAX_FRAME_BYTES);
    localparam logic [11:0] FCS_PLUS_ONE  = 12'd5;

    rx_state_t   state;
    logic        speed_100;
    logic [11:0] byte_count;
    logic [7:0]  gap_count;
    logic [31:0] crc_reg;
    logic [31:0] crc_seed;
    logic [31:0] crc_next;
    logic [7:0]  delay_line [5];

    logic        start_frame;
    logic        accept_byte;
    logic        gap_timeout;
    logic        end_frame;
    logic [7:0]  gap_limit;

    function automatic logic [11:0] count_increment(input logic [11:0] count);
        return (count == 12'hFFF) ? count : count + 12'd1;
    endfunction

    function automatic logic [10:0] payload_length(input logic [11:0] count);
        logic [11:0] payload;
        payload = count - 12'd4;
        return (payload > 12'd2047) ? 11'h7FF : payload[10:0];
    endfunction

    // A flagged byte always opens a new frame, whatever state we are in.
    assign start_frame = packaged_data_valid && packaged_data[8];
    assign accept_byte = packaged_data_valid && !packaged_data[8] && (state == S_RECEIVE);
    assign gap_limit   = speed_100 ? GAP_LIMIT_100 : GAP_LIMIT_10;
    assign gap_timeout = (state == S_RECEIVE) && !packaged_data_valid && (gap_count == gap_limit);
    assign end_frame   = (state == S_RECEIVE) && (gap_timeout || start_frame);
    assign crc_seed    = start_frame ? 32'hFFFF_FFFF : crc_reg;

    rmii_crc32_byte crc_update (
        .crc_in  (crc_seed),
        .data_in (packaged_data[7:0]),
        .crc_out (crc_next)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            speed_100          <= 1'b0;
            byte_count         <= 12'd0;
            gap_count          <= 8'd0;
            crc_reg            <= 32'hFFFF_FFFF;
            for (int i = 0; i < 5; i++) delay_line[i] <= 8'd0;
            frame_data         <= 8'd0;
            frame_data_valid   <= 1'b0;
            frame_data_last    <= 1'b0;
            frame_crc_error    <= 1'b0;
            frame_length_error <= 1'b0;
            frame_length       <= 11'd0;
            runt_drop_pulse    <= 1'b0;
        end else begin
            frame_data         <= 8'd0;
            frame_data_valid   <= 1'b0;
            frame_data_last    <= 1'b0;
            frame_crc_error    <= 1'b0;
            frame_length_error <= 1'b0;
            frame_length       <= 11'd0;
            runt_drop_pulse    <= 1'b0;

            // Closing beat: the oldest delay-line entry is the last payload byte.
            if (end_frame) begin
                if (byte_count >= FCS_PLUS_ONE) begin
                    frame_data         <= delay_line[4];
                    frame_data_valid   <= 1'b1;
                    frame_data_last    <= 1'b1;
                    frame_length       <= payload_length(byte_count);
                    frame_crc_error    <= (crc_reg != CRC32_RESIDUE);
                    frame_length_error <= (byte_count < MIN_BYTES) || (byte_count > MAX_BYTES);
                end else begin
                    runt_drop_pulse <= 1'b1;
                end
            end

            if (accept_byte) begin
                if (byte_count >= FCS_PLUS_ONE) begin
                    frame_data       <= delay_line[4];
                    frame_data_valid <= 1'b1;
                end
                delay_line[0] <= packaged_data[7:0];
                for (int i = 1; i < 5; i++) delay_line[i] <= delay_line[i-1];
                crc_reg    <= crc_next;
                byte_count <= count_increment(byte_count);
                gap_count  <= 8'd0;
            end else if ((state == S_RECEIVE) && !start_frame) begin
                gap_count <= gap_count + 8'd1;
            end

            if (start_frame) begin
                speed_100     <= (speed_code == SPEED_CODE_100_MEGABIT);
                delay_line[0] <= packaged_data[7:0];
                crc_reg       <= crc_next;
                byte_count    <= 12'd1;
                gap_count     <= 8'd0;
                state         <= S_RECEIVE;
            end else if (gap_timeout) begin
                state <= S_FINISH;
            end else if (state == S_FINISH) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: doc/rmii_frame_receiver.md
Name: rmii_frame_receiver

Overview:
Sits directly downstream of the RMII byte packager. It consumes flagged bytes (bit 8 = first byte of frame) together with the detected speed code. It delimits frames by inter-byte gap timeout or by a new first-byte flag, runs CRC-32 over each frame, and strips the 4-byte FCS. It emits a byte stream with a last marker, the payload length and per-frame error bits to the switch ingress logic.

Parameters:
GAP_CYCLES_100, 8, idle clocks without a byte that end a frame at 100 Mb (bytes arrive every 4 clocks)
GAP_CYCLES_10, 80, idle clocks without a byte that end a frame at 10 Mb (bytes arrive every 40 clocks)
MIN_FRAME_BYTES, 64, minimum frame length including FCS; shorter frames are runts
MAX_FRAME_BYTES, 1522, maximum frame length including FCS

Ports:
clock  in  1  system clock
reset_n  in  1  reset; synchronous, active-low; clock is clock
packaged_data  in  9  [7:0] byte, [8] first-byte-of-frame flag
packaged_data_valid  in  1  single-cycle byte strobe
speed_code  in  2  1 = 100 Mb, 0 = 10 Mb
frame_data  out  8  payload byte
frame_data_valid  out  1  payload byte strobe; no backpressure, consumer must accept
frame_data_last  out  1  high on the final payload beat
frame_crc_error  out  1  valid with last; FCS mismatch
frame_length_error  out  1  valid with last; runt or oversize
frame_length  out  11  valid with last; payload bytes excluding FCS, saturates at 2047
runt_drop_pulse  out  1  one-cycle pulse when a frame of fewer than 5 bytes is discarded

Behaviour:
- Reset: all outputs 0; state S_IDLE; delay line, byte count and gap counter cleared; CRC register 0xFFFFFFFF.
- States:
  - S_IDLE: on valid with flag = 1, latch speed_code, load the byte, set count = 1, reset CRC and feed the byte, go to S_RECEIVE. A valid byte with flag = 0 is ignored.
  - S_RECEIVE: each valid byte shifts into a 5-deep delay line, updates the CRC and increments count (count saturates). Gap counter clears on valid and increments otherwise.
  - S_FINISH: one cycle. Emits the final beat, then returns to S_IDLE.
- Output timing: when byte k+5 is accepted in cycle t, byte k appears on frame_data with valid = 1 and last = 0 at t+1.
- End of frame is declared when either:
  - the gap counter reaches GAP_CYCLES for the latched speed, or
  - a valid byte with flag = 1 arrives while in S_RECEIVE.
- Final beat, in the cycle after end is declared with count N >= 5:
  - frame_data = oldest delay-line entry, which is the last payload byte; valid = last = 1.
  - frame_length = N-4.
  - crc_error = (CRC register != 0xDEBB20E3 residue). The register is reflected, init all ones, no final XOR, and runs over the FCS bytes too.
  - length_error = (N < MIN_FRAME_BYTES) or (N > MAX_FRAME_BYTES).
- N < 5: no beats are emitted; runt_drop_pulse = 1 for one cycle instead.
- Restart on flag: the restarting byte starts a new frame immediately and is not part of the old frame. The old frame's final beat is emitted the next cycle. That cycle cannot collide with a new-frame payload beat, because the first new beat needs 5 bytes.
- Gap timeout and a first-byte flag in the same cycle: treated as a single end of frame; the flagged byte starts the new frame.
- Oversize frames keep streaming. Only the error bit marks them; frame_length saturates.
- Error, length and last outputs are 0 on non-last beats. All outputs are registered.
- Reset mid-frame: the frame is abandoned with no final beat. The first beat after reset requires a new flagged byte.

Decomposition:
- Package rmii_pkg holds:
  - speed code constants (SPEED_CODE_100_MEGABIT = 1, SPEED_CODE_10_MEGABIT = 0), shared with the packager
  - CRC32_POLY_REFLECTED = 0xEDB88320
  - CRC32_RESIDUE = 0xDEBB20E3
  - the receiver state enum
- Sub-module rmii_crc32_byte: combinational next-CRC from the current CRC and one data byte, LSB-first. It is reusable by the transmit path.

Test Plan:
- 100 Mb, flagged 64-byte frame with valid FCS, one byte every 4 clocks: 60 beats, last on the 60th, frame_length = 60, both error bits 0.
- Same frame with one payload bit flipped: 60 beats, crc_error = 1 on last, length_error = 0.
- 10 Mb speed code, 64-byte good frame, one byte every 40 clocks: last beat exactly 81 clocks after the final byte strobe (80-clock gap plus 1), no errors.
- 20-byte frame with correct FCS: 16 beats, frame_length = 16, length_error = 1, crc_error = 0.
- Good 64-byte frame immediately followed by a flagged byte 4 clocks after its last byte: old frame last beat at t+1, no gap wait; second frame delimits independently. Also a 3-byte frame: runt_drop_pulse once, zero beats.
- reset_n low for 1 cycle at byte 30 of a frame, then bytes continue with flag = 0: no output beats; the next flagged good frame is received normally.
